// File: rtl/axis_spike_counter_pkg.sv
// spike_counter_config: width helpers and state encoding shared by the spike counter slice.
package spike_counter_config;
    localparam int NET_NUM_OUT = 4;
    typedef enum logic {ACCUM, DUMP} state_t;
    function automatic int width_nearest_byte(input int w);
        return ((w + 7) / 8) * 8;
    endfunction
    function automatic int idx_width(input int n);
        return n > 1 ? $clog2(n) : 1;
    endfunction
    function automatic int in_width(input int num_out);
        return width_nearest_byte(num_out);
    endfunction
    function automatic int out_width(input int cnt_width, input int num_out);
        return width_nearest_byte(cnt_width + idx_width(num_out));
    endfunction
endpackage

// File: rtl/axis_spike_counter_saturating_counter.sv
// saturating_counter: up-counter that sticks at all-ones; clear wins over increment.
module saturating_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             arstn,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] q
);
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) q <= '0;
        else if (clr) q <= '0;
        else if (inc && q != '1) q <= q + 1'b1;
    end
endmodule

// File: rtl/axis_spike_counter.sv
// axis_spike_counter: counts output-neuron fires over a window, then streams one {idx, count} beat per neuron.
module axis_spike_counter
    import spike_counter_config::*;
#(
    parameter int NUM_OUT   = NET_NUM_OUT,
    parameter int CNT_WIDTH = 16,
    parameter int WINDOW    = 1000,
    parameter int IDX_WIDTH = idx_width(NUM_OUT),
    parameter int IN_WIDTH  = in_width(NUM_OUT),
    parameter int OUT_WIDTH = out_width(CNT_WIDTH, NUM_OUT)
) (
    input  logic                 clk,
    input  logic                 arstn,
    input  logic                 flush,
    input  logic                 i_s_axis_tvalid,
    output logic                 o_s_axis_tready,
    input  logic [IN_WIDTH-1:0]  i_s_axis_tdata,
    output logic                 o_m_axis_tvalid,
    input  logic                 i_m_axis_tready,
    output logic [OUT_WIDTH-1:0] o_m_axis_tdata
);
    localparam int STEP_WIDTH = WINDOW > 1 ? $clog2(WINDOW) : 1;

    state_t                  r_state;
    logic                    r_ready;
    logic [STEP_WIDTH-1:0]   r_step;
    logic [IDX_WIDTH-1:0]    r_idx;
    logic [CNT_WIDTH-1:0]    w_cnt [NUM_OUT];
    logic                    w_hs_in;
    logic                    w_hs_out;
    logic                    w_last_out;
    logic                    w_end_window;
    logic                    w_unused;

    assign w_unused        = ^i_s_axis_tdata;
    // r_ready keeps tready low until the first clock after reset release
    assign o_s_axis_tready = r_ready && r_state == ACCUM;
    assign o_m_axis_tvalid = r_state == DUMP;
    assign w_hs_in         = i_s_axis_tvalid && o_s_axis_tready;
    assign w_hs_out        = o_m_axis_tvalid && i_m_axis_tready;
    assign w_last_out      = w_hs_out && r_idx == IDX_WIDTH'(NUM_OUT - 1);
    assign w_end_window    = (w_hs_in && r_step == STEP_WIDTH'(WINDOW - 1)) || flush;

    for (genvar i = 0; i < NUM_OUT; i++) begin : g_cnt
        saturating_counter #(.WIDTH(CNT_WIDTH)) u_cnt (
            .clk   (clk),
            .arstn (arstn),
            .inc   (w_hs_in && i_s_axis_tdata[i]),
            .clr   (w_last_out),
            .q     (w_cnt[i])
        );
    end

    always_comb begin
        o_m_axis_tdata = '0;
        if (o_m_axis_tvalid) begin
            o_m_axis_tdata[CNT_WIDTH-1:0]         = w_cnt[r_idx];
            o_m_axis_tdata[CNT_WIDTH +: IDX_WIDTH] = r_idx;
        end
    end

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            r_state <= ACCUM;
            r_ready <= 1'b0;
            r_step  <= '0;
            r_idx   <= '0;
        end else begin
            r_ready <= 1'b1;
            if (r_state == ACCUM) begin
                if (w_hs_in) r_step <= r_step + 1'b1;
                if (w_end_window) begin
                    r_state <= DUMP;
                    r_step  <= '0;
                end
            end else if (w_last_out) begin
                r_state <= ACCUM;
                r_step  <= '0;
                r_idx   <= '0;
            end else if (w_hs_out) begin
                r_idx <= r_idx + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_axis_spike_counter.sv
// tb_axis_spike_counter: directed checks of accumulate/dump behaviour with hand-computed beats.
module tb_axis_spike_counter;
    logic       clk = 1'b0;
    logic       arstn = 1'b0;
    logic       flush = 1'b0;
    logic       s_tvalid = 1'b0;
    logic       s2_tvalid = 1'b0;
    logic [7:0] s_tdata = '0;
    logic       m_tready = 1'b1;
    logic       s_tready, s2_tready;
    logic       m_tvalid, m2_tvalid;
    logic [7:0] m_tdata, m2_tdata;
    int         n_tests = 0;
    int         n_fail = 0;

    always #5 clk = ~clk;

    axis_spike_counter #(.NUM_OUT(4), .CNT_WIDTH(4), .WINDOW(3)) dut (
        .clk(clk), .arstn(arstn), .flush(flush),
        .i_s_axis_tvalid(s_tvalid), .o_s_axis_tready(s_tready), .i_s_axis_tdata(s_tdata),
        .o_m_axis_tvalid(m_tvalid), .i_m_axis_tready(m_tready), .o_m_axis_tdata(m_tdata)
    );

    axis_spike_counter #(.NUM_OUT(4), .CNT_WIDTH(4), .WINDOW(20)) dut_sat (
        .clk(clk), .arstn(arstn), .flush(1'b0),
        .i_s_axis_tvalid(s2_tvalid), .o_s_axis_tready(s2_tready), .i_s_axis_tdata(s_tdata),
        .o_m_axis_tvalid(m2_tvalid), .i_m_axis_tready(m_tready), .o_m_axis_tdata(m2_tdata)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [7:0] d, input logic f);
        s_tvalid = 1'b1;
        s_tdata  = d;
        flush    = f;
        tick();
        s_tvalid = 1'b0;
        flush    = 1'b0;
    endtask

    task automatic window3(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        beat(a, 1'b0);
        beat(b, 1'b0);
        beat(c, 1'b0);
    endtask

    task automatic dump(input string tag, input logic [31:0] e);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("%s tvalid%0d", tag, k), m_tvalid, 1);
            check($sformatf("%s tdata%0d", tag, k), m_tdata, e[8*(3-k) +: 8]);
            tick();
        end
        check({tag, " end tvalid"}, m_tvalid, 0);
        check({tag, " end s_tready"}, s_tready, 1);
    endtask

    initial begin
        #2;
        check("rst s_tready", s_tready, 0);
        check("rst m_tvalid", m_tvalid, 0);
        check("rst m_tdata", m_tdata, 0);
        tick();
        tick();
        arstn = 1'b1;
        tick();
        check("post-rst s_tready", s_tready, 1);

        window3(8'h5, 8'h7, 8'h1);
        dump("basic", 32'h03_11_22_30);

        s2_tvalid = 1'b1;
        s_tdata   = 8'hF;
        for (int k = 0; k < 20; k++) tick();
        s2_tvalid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check($sformatf("sat tvalid%0d", k), m2_tvalid, 1);
            check($sformatf("sat tdata%0d", k), m2_tdata, 8'h0F | 8'(k << 4));
            tick();
        end
        check("sat end tvalid", m2_tvalid, 0);

        beat(8'h8, 1'b1);
        dump("flush beat", 32'h00_10_20_31);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        dump("flush idle", 32'h00_10_20_30);

        window3(8'h5, 8'h7, 8'h1);
        check("bp beat0", m_tdata, 8'h03);
        tick();
        m_tready = 1'b0;
        s_tvalid = 1'b1;
        s_tdata  = 8'hF;
        for (int k = 0; k < 5; k++) begin
            check("bp hold tdata", m_tdata, 8'h11);
            check("bp hold tvalid", m_tvalid, 1);
            check("bp hold s_tready", s_tready, 0);
            tick();
        end
        m_tready = 1'b1;
        s_tvalid = 1'b0;
        check("bp beat1", m_tdata, 8'h11);
        tick();
        check("bp beat2", m_tdata, 8'h22);
        tick();
        check("bp beat3", m_tdata, 8'h30);
        tick();
        check("bp end s_tready", s_tready, 1);
        check("bp end tvalid", m_tvalid, 0);

        window3(8'h2, 8'h2, 8'h2);
        tick();
        check("rst-mid beat1", m_tdata, 8'h13);
        arstn = 1'b0;
        #1;
        check("rst-mid tvalid", m_tvalid, 0);
        check("rst-mid tdata", m_tdata, 0);
        check("rst-mid s_tready", s_tready, 0);
        tick();
        arstn = 1'b1;
        tick();
        window3(8'h2, 8'h2, 8'h2);
        dump("after rst", 32'h00_13_20_30);

        window3(8'hF, 8'hF, 8'hF);
        dump("b2b first", 32'h03_13_23_33);
        window3(8'h1, 8'h1, 8'h1);
        dump("b2b second", 32'h03_10_20_30);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
